// File: rtl/riscv_memreq_queue.sv
// Physical memory request queue between the no-MMU translation stage and the BIU.
// Screens incoming requests for page faults and misalignment, then buffers clean ones in a FIFO.
package riscv_memreq_pkg;
  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;
endpackage

module riscv_memreq_queue
  import riscv_memreq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PLEN  = (XLEN == 32) ? 34 : 56,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            req_i,
  input  logic [PLEN-1:0] adr_i,
  input  biu_size_t       size_i,
  input  logic            lock_i,
  input  logic            we_i,
  input  logic            pagefault_i,
  output logic            stall_o,
  output logic            req_o,
  output logic [PLEN-1:0] adr_o,
  output biu_size_t       size_o,
  output logic            lock_o,
  output logic            we_o,
  input  logic            ack_i,
  output logic            misaligned_o,
  output logic            pagefault_o,
  output logic [PLEN-1:0] exc_adr_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [PLEN-1:0] adr;
    biu_size_t       size;
    logic            lock;
    logic            we;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_req;
  logic            r_stall;
  logic            r_misaligned;
  logic            r_pagefault;
  logic [PLEN-1:0] r_exc_adr;

  logic            w_misaligned;
  logic            w_fault;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [PW-1:0]   w_wr_nxt;
  logic [PW-1:0]   w_rd_nxt;
  logic [CW-1:0]   w_count_nxt;

  // alignment check on the incoming request
  always_comb begin
    w_misaligned = 1'b0;
    case (size_i)
      HWORD:   w_misaligned = (adr_i[0]   != 1'b0);
      WORD:    w_misaligned = (adr_i[1:0] != 2'b00);
      DWORD:   w_misaligned = (adr_i[2:0] != 3'b000);
      QWORD:   w_misaligned = (adr_i[3:0] != 4'b0000);
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_fault = pagefault_i | w_misaligned;
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = req_i & ~flush_i & ~w_fault & ~w_full;
  assign w_pop   = r_req & ack_i;

  // next pointers/count; a flush keeps only an unacknowledged head
  always_comb begin
    w_wr_nxt    = r_wr_ptr;
    w_rd_nxt    = r_rd_ptr;
    w_count_nxt = r_count;
    if (flush_i) begin
      if (w_pop) begin
        w_rd_nxt    = r_rd_ptr + PW'(1);
        w_wr_nxt    = r_rd_ptr + PW'(1);
        w_count_nxt = CW'(0);
      end else if (r_req) begin
        w_wr_nxt    = r_rd_ptr + PW'(1);
        w_count_nxt = CW'(1);
      end else begin
        w_wr_nxt    = r_rd_ptr;
        w_count_nxt = CW'(0);
      end
    end else begin
      if (w_push) begin
        w_wr_nxt = r_wr_ptr + PW'(1);
      end else begin
        w_wr_nxt = r_wr_ptr;
      end
      if (w_pop) begin
        w_rd_nxt = r_rd_ptr + PW'(1);
      end else begin
        w_rd_nxt = r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // queue state, handshake flags and fault pulses
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '{adr: '0, size: BYTE, lock: 1'b0, we: 1'b0};
      end
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_req        <= 1'b0;
      r_stall      <= 1'b0;
      r_misaligned <= 1'b0;
      r_pagefault  <= 1'b0;
      r_exc_adr    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{adr: adr_i, size: size_i, lock: lock_i, we: we_i};
      end
      r_wr_ptr     <= w_wr_nxt;
      r_rd_ptr     <= w_rd_nxt;
      r_count      <= w_count_nxt;
      r_req        <= (w_count_nxt != CW'(0));
      r_stall      <= (w_count_nxt == CW'(DEPTH));
      r_pagefault  <= req_i & ~flush_i & pagefault_i;
      r_misaligned <= req_i & ~flush_i & ~pagefault_i & w_misaligned;
      if (req_i & ~flush_i & w_fault) begin
        r_exc_adr <= adr_i;
      end
    end
  end

  assign req_o        = r_req;
  assign stall_o      = r_stall;
  assign misaligned_o = r_misaligned;
  assign pagefault_o  = r_pagefault;
  assign exc_adr_o    = r_exc_adr;
  assign adr_o        = r_mem[r_rd_ptr].adr;
  assign size_o       = r_mem[r_rd_ptr].size;
  assign lock_o       = r_mem[r_rd_ptr].lock;
  assign we_o         = r_mem[r_rd_ptr].we;

endmodule

// File: doc/riscv_memreq_queue.md
Name: riscv_memreq_queue

Overview:
- Physical request queue directly downstream of the no-MMU translation stage.
- Accepts registered physical requests (req/adr/size/lock/we/pagefault) and screens them for misalignment and page faults.
- Buffers clean requests in a small FIFO and presents them to the bus interface unit with a hold-until-ack handshake.
- Back-pressures the translation stage through stall_o.

Parameters:
- XLEN, 32, CPU data width; only used to derive the PLEN default.
- PLEN, XLEN==32 ? 34 : 56, physical address width.
- DEPTH, 2, number of queue entries; power of 2, minimum 2.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, synchronous, active-low
- flush_i  input  1  pipeline flush
- req_i  input  1  request valid from translation stage
- adr_i  input  PLEN  physical address
- size_i  input  biu_size_t  access size (BYTE/HWORD/WORD/DWORD/QWORD)
- lock_i  input  1  locked/atomic access
- we_i  input  1  write enable
- pagefault_i  input  1  translation fault for this request
- stall_o  output  1  queue full; upstream holds its outputs
- req_o  output  1  request valid to BIU
- adr_o  output  PLEN  head entry address
- size_o  output  biu_size_t  head entry size
- lock_o  output  1  head entry lock
- we_o  output  1  head entry write enable
- ack_i  input  1  BIU accepts the head request
- misaligned_o  output  1  one-cycle pulse: misaligned request rejected
- pagefault_o  output  1  one-cycle pulse: page-faulted request rejected
- exc_adr_o  output  PLEN  address of the rejected request

Behaviour:
- Reset is synchronous, active-low, sampled on the clk_i rising edge. On reset:
  - Queue is empty; read/write pointers and count are 0.
  - req_o=0, stall_o=0, misaligned_o=0, pagefault_o=0.
  - exc_adr_o=0, adr_o=0, size_o=BYTE, lock_o=0, we_o=0.
- Reset mid-transaction drops all entries. No ack is expected afterwards.
- Misalignment check on the incoming request:
  - HWORD: adr_i[0]!=0.
  - WORD: adr_i[1:0]!=0.
  - DWORD: adr_i[2:0]!=0.
  - QWORD: adr_i[3:0]!=0.
  - BYTE is never misaligned.
- Fault handling when req_i=1 and flush_i=0:
  - pagefault_i=1: the request is not enqueued. Next cycle pagefault_o=1 and exc_adr_o=adr_i.
  - pagefault_i takes priority. misaligned_o=0 when both conditions hold.
  - Else if misaligned: not enqueued. Next cycle misaligned_o=1 and exc_adr_o=adr_i.
  - Each flag is a single-cycle pulse and is otherwise 0. exc_adr_o holds its value between faults.
- Push: req_i & !flush_i & !fault & !full writes {adr,size,lock,we} at the write pointer.
- Pop: req_o & ack_i advances the read pointer.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Push and pop in the same cycle leave count unchanged.
- Push while full is blocked, even if a pop occurs in the same cycle. The upstream stage holds its request.
- stall_o = (count==DEPTH), registered. It deasserts the cycle after the first pop from full.
- req_o = (count!=0), registered; it rises one cycle after the push that makes the queue non-empty.
- adr_o/size_o/lock_o/we_o always reflect the head entry. They are stable while req_o=1 and ack_i=0.
- Handshake rule: once req_o=1, req_o and the head fields stay constant until ack_i=1. ack_i is ignored while req_o=0.
- Flush with flush_i=1:
  - Incoming req_i is discarded; no fault pulse is generated.
  - If req_o=1 and ack_i=0: the head entry is retained, all others are discarded, count becomes 1, and req_o stays high until acked.
  - If req_o=1 and ack_i=1: the head is popped normally and the queue becomes empty.
  - If req_o=0: the queue stays empty.
  - stall_o=0 in the cycle after any flush.
- Throughput: one push and one pop per cycle in steady state, with no bubbles when DEPTH>=2.

Test Plan:
1. Reset then single push: WORD write to 0x0_0000_1000, ack_i=1 two cycles later -> req_o=1 one cycle after push with adr_o=0x1000, size_o=WORD, we_o=1; req_o=0 after ack; count returns to 0.
2. Fill DEPTH=2 with ack_i=0 (reads at 0x100, 0x104), third req_i at 0x108 -> stall_o=1, third request not enqueued. Assert ack_i once -> stall_o=0 next cycle, head becomes 0x104, and 0x108 is then accepted.
3. Misalignment sweep: HWORD@0x1001, WORD@0x1002, DWORD@0x1004, BYTE@0x1003 -> misaligned_o pulses for the first three with exc_adr_o equal to each address; BYTE is enqueued and no pulse occurs.
4. pagefault_i=1 with a misaligned WORD@0x2003 -> pagefault_o=1, misaligned_o=0, exc_adr_o=0x2003, nothing enqueued, req_o stays 0.
5. Queue holds 0x300 (head, req_o=1, ack_i=0) and 0x304; flush_i=1 with req_i=1 @0x308 -> next cycle count=1, req_o=1, adr_o=0x300. After ack, req_o=0; 0x304 and 0x308 never appear.
6. Back-to-back streaming of 16 requests with ack_i tied 1 -> 16 pops in 16 consecutive cycles, addresses in order, stall_o never asserts. Then rst_ni=0 mid-stream -> req_o=0 on the next edge.
